// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed 4-digit seven-segment driver with blanking gaps, shadowed frame-atomic updates and leading-zero suppression
module seven_seg_scanner #(
  parameter int DRIVE_CYCLES = 100000,
  parameter int GAP_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank,
  input  logic        lz_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_tick
);
  localparam int MAXC = DRIVE_CYCLES > GAP_CYCLES ? DRIVE_CYCLES : GAP_CYCLES;
  localparam int W = $clog2(MAXC + 1);
  localparam logic [6:0] LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  typedef enum logic {GAP, DRIVE} state_t;
  state_t state, state_n;
  logic [1:0] idx, idx_n;
  logic [W-1:0] cnt, cnt_n;
  logic [15:0] disp, shadow;
  logic [3:0] disp_dp, shadow_dp;
  logic last, boundary, dark;
  logic [3:0] nib;
  // next scan position and the visibility of the digit currently selected
  always_comb begin
    last = (state == GAP) ? (cnt == W'(GAP_CYCLES - 1)) : (cnt == W'(DRIVE_CYCLES - 1));
    state_n = last ? ((state == GAP) ? DRIVE : GAP) : state;
    idx_n = (last && state == DRIVE) ? idx + 2'd1 : idx;
    cnt_n = last ? '0 : cnt + W'(1);
    boundary = last && state == DRIVE && idx == 2'd3;
    nib = disp[{idx, 2'b00} +: 4];
    dark = blank[idx] | (lz_en && idx != 2'd0 && (disp >> {idx, 2'b00}) == 16'd0);
  end
  // scan state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= GAP;
      idx <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
    end
  end
  // shadow capture and frame-atomic hand-over to the display registers
  always_ff @(posedge clk) begin
    if (reset) begin
      disp <= '0;
      disp_dp <= '0;
      shadow <= '0;
      shadow_dp <= '0;
      pending <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      if (boundary && pending) begin
        disp <= shadow;
        disp_dp <= shadow_dp;
      end
      if (load) begin
        shadow <= data;
        shadow_dp <= dp_in;
      end
      pending <= load | (pending & ~boundary);
      frame_tick <= boundary;
    end
  end
  // registered active-low pin drive, dark during gaps and suppressed digits
  always_ff @(posedge clk) begin
    if (reset || state == GAP || dark) begin
      an <= 4'hF;
      seg <= 7'h7F;
      dp <= 1'b1;
    end else begin
      an <= ~(4'b0001 << idx);
      seg <= LUT[nib];
      dp <= ~disp_dp[idx];
    end
  end
endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter DRIVE_CYCLES, default 100000, clock cycles each digit is driven; SHALL be >= 1.
REQ-002 Parameter GAP_CYCLES, default 1000, clock cycles of all-off blanking before each digit (anti-ghosting); SHALL be >= 1.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data  input  16  four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-006 load  input  1  one-cycle strobe that captures data/dp_in into the shadow register.
REQ-007 dp_in  input  4  decimal point per digit, 1 = lit.
REQ-008 blank  input  4  per-digit force-off, 1 = digit dark; sampled live, not shadowed.
REQ-009 lz_en  input  1  leading-zero suppression enable; sampled live.
REQ-010 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 dp  output  1  decimal-point cathode, active-low, registered.
REQ-012 an  output  4  anodes, active-low, one-hot-low while driving, registered.
REQ-013 pending  output  1  1 = shadow holds data not yet shown.
REQ-014 frame_tick  output  1  one-cycle pulse at each frame boundary.

Function
REQ-015 The FSM SHALL have two states, GAP and DRIVE, with a 2-bit digit index idx and a cycle counter that runs 0..N-1 in each state (N = GAP_CYCLES or DRIVE_CYCLES) and clears on every state change.
REQ-016 GAP SHALL go to DRIVE with idx unchanged when its counter reaches GAP_CYCLES-1.
REQ-017 DRIVE SHALL go to GAP when its counter reaches DRIVE_CYCLES-1; idx SHALL increment modulo 4, wrapping 3 -> 0.
REQ-018 Frame period SHALL be exactly 4*(GAP_CYCLES+DRIVE_CYCLES) cycles.
REQ-019 In GAP, outputs SHALL be an=4'b1111, seg=7'b1111111, dp=1.
REQ-020 In DRIVE, an SHALL be all ones except bit idx = 0, seg SHALL be the decode of display nibble idx, and dp SHALL be ~disp_dp[idx].
REQ-021 The decode SHALL be: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
REQ-022 A digit SHALL be dark (an bit 1, seg all 1, dp 1) during its DRIVE slot if blank[idx]=1, or if lz_en=1, idx>=1, and display nibbles idx..3 are all zero; digit 0 SHALL never be zero-suppressed.
REQ-023 Output registers SHALL reflect state with one cycle latency: the cycle after a state/idx change, outputs show the new state.
REQ-024 On load=1 the shadow SHALL capture data and dp_in and pending SHALL become 1; a load while pending=1 SHALL overwrite the shadow (latest wins).
REQ-025 The frame boundary is the DRIVE->GAP transition with idx=3; frame_tick SHALL be 1 for exactly that cycle.
REQ-026 At the frame boundary, if pending=1, the display registers SHALL take the shadow and pending SHALL clear, so a frame never mixes old and new digits.
REQ-027 If load coincides with the frame boundary, the previously pending shadow (if any) SHALL be displayed, the new data SHALL be captured, and pending SHALL be 1 after that cycle.

Reset
REQ-028 While reset=1: state=GAP, idx=0, counter=0, display and shadow registers=0, pending=0, frame_tick=0, an=4'b1111, seg=7'b1111111, dp=1.
REQ-029 Reset SHALL override load and any scan in progress; the first digit-0 DRIVE SHALL begin GAP_CYCLES cycles after reset deasserts.

Verification
REQ-030 GAP=2, DRIVE=4, reset released -> an sequence 1111(2) 1110(4) 1111(2) 1101(4) 1111(2) 1011(4) 1111(2) 0111(4) repeating; frame_tick every 24 cycles.
REQ-031 load with data=16'h12AF, dp_in=4'b0100 mid-frame -> pending=1 until the next frame_tick, then slots show F=0001110, A=0001000, 2=0100100, 1=1111001; dp=0 only in the digit-2 slot; pending=0.
REQ-032 Two loads (16'h1111 then 16'h2222) within one frame -> next frame shows all 2s; 1111 never displayed.
REQ-033 lz_en=1, data=16'h0070 -> digits 3 and 2 dark, digit 1 shows 7, digit 0 shows 0; data=16'h0000 -> only digit 0 lit, showing 1000000.
REQ-034 load on the frame_tick cycle while pending=0 -> old value held for one more full frame, new value shown after the following frame_tick.
REQ-035 reset asserted during a DRIVE slot of digit 2 -> next cycle an=1111, pending=0, display=0; after release, scan restarts at digit 0.
